sdram_arbiter: RTL and testbench

// - Shares the single SDRAMBus port between the five AcappellaCore clients: record, play, mix, pitch and loaddata.
// - Clients keep their existing read/write/addr/writedata/readdata/finished handshake.
// - Real-time clients (record, play) win by fixed priority; background clients (mix, pitch, loaddata) share the remainder round-robin.
// - Replaces the hard-wired sdram_* assigns in AcappellaCore.

---
 rtl/acappella_pkg.sv | 20 ++
 rtl/rr_picker.sv | 45 ++++
 rtl/sdram_arbiter.sv | 171 +++++++++++++++++
 tb/tb_sdram_arbiter.sv | 383 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/acappella_pkg.sv
// Definitions shared by the AcappellaCore SDRAM arbiter: client map, bus widths, arbiter states.
package acappella_pkg;

  localparam int CLI_RECORD = 0;
  localparam int CLI_PLAY   = 1;
  localparam int CLI_MIX    = 2;
  localparam int CLI_PITCH  = 3;
  localparam int CLI_LOAD   = 4;

  localparam int SDRAM_ADDR_W = 23;
  localparam int SDRAM_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } arb_state_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin pick over the background clients (RT_CLIENTS..NUM_CLIENTS-1),
// starting the search at i_ptr and wrapping back to RT_CLIENTS.
module rr_picker #(
  parameter int NUM_CLIENTS = 5,
  parameter int RT_CLIENTS  = 2,
  parameter int IDX_W       = 3
) (
  input  logic [NUM_CLIENTS-1:0] i_mask,
  input  logic [IDX_W-1:0]       i_ptr,
  output logic                   o_valid,
  output logic [IDX_W-1:0]       o_index
);

  localparam int NB = NUM_CLIENTS - RT_CLIENTS;
  localparam logic [IDX_W:0] C_NUM = (IDX_W + 1)'(NUM_CLIENTS);
  localparam logic [IDX_W:0] C_NB  = (IDX_W + 1)'(NB);

  logic [IDX_W-1:0] w_cand_idx [NB];
  logic [NB-1:0]    w_hit;

  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_off
      logic [IDX_W:0] w_sum;
      logic [IDX_W:0] w_wrap;
      assign w_sum            = {1'b0, i_ptr} + (IDX_W + 1)'(gi);
      assign w_wrap           = (w_sum >= C_NUM) ? (w_sum - C_NB) : w_sum;
      assign w_cand_idx[gi]   = w_wrap[IDX_W-1:0];
      assign w_hit[gi]        = i_mask[w_cand_idx[gi]];
    end
  endgenerate

  // Scan downwards so the smallest offset from the pointer has the final say.
  always_comb begin
    o_valid = 1'b0;
    o_index = '0;
    for (int i = NB - 1; i >= 0; i--) begin
      if (w_hit[i]) begin
        o_valid = 1'b1;
        o_index = w_cand_idx[i];
      end
    end
  end

endmodule

// File: rtl/sdram_arbiter.sv
// Shares one SDRAMBus port among the AcappellaCore clients: fixed priority for the
// real-time clients, round-robin for the background ones, with a watchdog on each transaction.
module sdram_arbiter
  import acappella_pkg::*;
#(
  parameter int NUM_CLIENTS = 5,
  parameter int RT_CLIENTS  = 2,
  parameter int ADDR_W      = SDRAM_ADDR_W,
  parameter int DATA_W      = SDRAM_DATA_W,
  parameter int TIMEOUT     = 1023
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [NUM_CLIENTS-1:0]        req_read,
  input  logic [NUM_CLIENTS-1:0]        req_write,
  input  logic [NUM_CLIENTS*ADDR_W-1:0] req_addr,
  input  logic [NUM_CLIENTS*DATA_W-1:0] req_writedata,
  output logic [DATA_W-1:0]             req_readdata,
  output logic [NUM_CLIENTS-1:0]        req_finished,
  output logic                          sdram_read,
  output logic                          sdram_write,
  output logic [ADDR_W-1:0]             sdram_addr,
  output logic [DATA_W-1:0]             sdram_writedata,
  input  logic [DATA_W-1:0]             sdram_readdata,
  input  logic                          sdram_finished,
  output logic                          o_timeout,
  output logic                          o_conflict
);

  localparam int IDX_W = $clog2(NUM_CLIENTS);
  localparam int WD_W  = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0]  WD_LIMIT = WD_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0] BG_FIRST = IDX_W'(RT_CLIENTS);
  localparam logic [IDX_W-1:0] BG_LAST  = IDX_W'(NUM_CLIENTS - 1);

  arb_state_t             r_state;
  logic [IDX_W-1:0]       r_idx;
  logic [IDX_W-1:0]       r_rr_ptr;
  logic [NUM_CLIENTS-1:0] r_holdoff;
  logic [WD_W-1:0]        r_wd;
  logic                   r_sdram_read;
  logic                   r_sdram_write;
  logic [ADDR_W-1:0]      r_sdram_addr;
  logic [DATA_W-1:0]      r_sdram_wdata;
  logic [DATA_W-1:0]      r_rdata;
  logic [NUM_CLIENTS-1:0] r_finished;
  logic                   r_timeout;
  logic                   r_conflict;

  logic [NUM_CLIENTS-1:0] w_cand;
  logic                   w_rt_valid;
  logic [IDX_W-1:0]       w_rt_idx;
  logic                   w_bg_valid;
  logic [IDX_W-1:0]       w_bg_idx;
  logic                   w_win_valid;
  logic [IDX_W-1:0]       w_win_idx;
  logic                   w_win_read;
  logic                   w_win_write;
  logic [ADDR_W-1:0]      w_win_addr;
  logic [DATA_W-1:0]      w_win_wdata;

  function automatic logic [IDX_W-1:0] next_bg(input logic [IDX_W-1:0] idx);
    if (idx == BG_LAST) return BG_FIRST;
    return idx + IDX_W'(1);
  endfunction

  // The client just served is masked for one IDLE cycle so a late request drop is not re-granted.
  assign w_cand = (req_read | req_write) & ~r_holdoff;

  always_comb begin
    w_rt_valid = 1'b0;
    w_rt_idx   = '0;
    for (int i = RT_CLIENTS - 1; i >= 0; i--) begin
      if (w_cand[i]) begin
        w_rt_valid = 1'b1;
        w_rt_idx   = IDX_W'(i);
      end
    end
  end

  rr_picker #(
    .NUM_CLIENTS (NUM_CLIENTS),
    .RT_CLIENTS  (RT_CLIENTS),
    .IDX_W       (IDX_W)
  ) u_rr_picker (
    .i_mask  (w_cand),
    .i_ptr   (r_rr_ptr),
    .o_valid (w_bg_valid),
    .o_index (w_bg_idx)
  );

  assign w_win_valid = w_rt_valid | w_bg_valid;
  assign w_win_idx   = w_rt_valid ? w_rt_idx : w_bg_idx;
  assign w_win_read  = req_read[w_win_idx];
  assign w_win_write = req_write[w_win_idx];
  assign w_win_addr  = req_addr[w_win_idx*ADDR_W +: ADDR_W];
  assign w_win_wdata = req_writedata[w_win_idx*DATA_W +: DATA_W];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state       <= IDLE;
      r_idx         <= '0;
      r_rr_ptr      <= BG_FIRST;
      r_holdoff     <= '0;
      r_wd          <= '0;
      r_sdram_read  <= 1'b0;
      r_sdram_write <= 1'b0;
      r_sdram_addr  <= '0;
      r_sdram_wdata <= '0;
      r_rdata       <= '0;
      r_finished    <= '0;
      r_timeout     <= 1'b0;
      r_conflict    <= 1'b0;
    end else begin
      r_finished <= '0;
      case (r_state)
        IDLE: begin
          r_holdoff <= '0;
          if (w_win_valid) begin
            r_idx         <= w_win_idx;
            r_sdram_read  <= ~w_win_write;
            r_sdram_write <= w_win_write;
            r_sdram_addr  <= w_win_addr;
            r_sdram_wdata <= w_win_wdata;
            if (w_win_read && w_win_write) r_conflict <= 1'b1;
            r_state <= ISSUE;
          end
        end
        ISSUE: begin
          r_wd    <= '0;
          r_state <= WAIT;
        end
        WAIT: begin
          // A completion arriving on the watchdog's last cycle wins over the abort.
          if (sdram_finished) begin
            r_sdram_read      <= 1'b0;
            r_sdram_write     <= 1'b0;
            r_rdata           <= sdram_readdata;
            r_finished[r_idx] <= 1'b1;
            r_state           <= DONE;
          end else if (r_wd == WD_LIMIT) begin
            r_sdram_read      <= 1'b0;
            r_sdram_write     <= 1'b0;
            r_rdata           <= '0;
            r_finished[r_idx] <= 1'b1;
            r_timeout         <= 1'b1;
            r_state           <= DONE;
          end else begin
            r_wd <= r_wd + WD_W'(1);
          end
        end
        DONE: begin
          r_holdoff <= NUM_CLIENTS'(1) << r_idx;
          if (r_idx >= BG_FIRST) r_rr_ptr <= next_bg(r_idx);
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req_readdata    = r_rdata;
  assign req_finished    = r_finished;
  assign sdram_read      = r_sdram_read;
  assign sdram_write     = r_sdram_write;
  assign sdram_addr      = r_sdram_addr;
  assign sdram_writedata = r_sdram_wdata;
  assign o_timeout       = r_timeout;
  assign o_conflict      = r_conflict;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter with a small SDRAMBus responder of programmable latency.
module tb_sdram_arbiter;
  import acappella_pkg::*;

  localparam int N  = 5;
  localparam int AW = 23;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            i_rst = 1'b1;
  logic [N-1:0]    req_read = '0;
  logic [N-1:0]    req_write = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*DW-1:0] req_writedata = '0;
  logic [DW-1:0]   req_readdata;
  logic [N-1:0]    req_finished;
  logic            sdram_read;
  logic            sdram_write;
  logic [AW-1:0]   sdram_addr;
  logic [DW-1:0]   sdram_writedata;
  logic [DW-1:0]   sdram_readdata = '0;
  logic            sdram_finished = 1'b0;
  logic            o_timeout;
  logic            o_conflict;

  int total = 0;
  int bad = 0;

  bit          model_en = 1'b1;
  int          model_lat = 3;
  logic [DW-1:0] model_data = 32'hCAFEBABE;

  sdram_arbiter #(
    .NUM_CLIENTS (N),
    .RT_CLIENTS  (2),
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .TIMEOUT     (15)
  ) dut (
    .i_clk           (clk),
    .i_rst           (i_rst),
    .req_read        (req_read),
    .req_write       (req_write),
    .req_addr        (req_addr),
    .req_writedata   (req_writedata),
    .req_readdata    (req_readdata),
    .req_finished    (req_finished),
    .sdram_read      (sdram_read),
    .sdram_write     (sdram_write),
    .sdram_addr      (sdram_addr),
    .sdram_writedata (sdram_writedata),
    .sdram_readdata  (sdram_readdata),
    .sdram_finished  (sdram_finished),
    .o_timeout       (o_timeout),
    .o_conflict      (o_conflict)
  );

  always #5 clk = ~clk;

  // SDRAM responder: pulses finished during the model_lat-th cycle the strobe is high.
  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(negedge clk);
      sdram_readdata = model_data;
      if (sdram_finished) begin
        sdram_finished = 1'b0;
        cnt = 0;
      end else if (model_en && (sdram_read || sdram_write)) begin
        cnt++;
        if (cnt >= model_lat) sdram_finished = 1'b1;
      end else begin
        cnt = 0;
      end
    end
  end

  task automatic set_client(input int i, input bit rd, input bit wr,
                            input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_read[i]               = rd;
    req_write[i]              = wr;
    req_addr[i*AW +: AW]      = a;
    req_writedata[i*DW +: DW] = d;
  endtask

  task automatic do_reset();
    @(negedge clk);
    req_read  = '0;
    req_write = '0;
    i_rst = 1'b1;
    @(negedge clk);
    i_rst = 1'b0;
  endtask

  // Returns at the first negedge showing a strobe; cyc = negedges waited.
  task automatic wait_grant(output bit ok, output int cyc);
    ok = 1'b0;
    cyc = 0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (sdram_read || sdram_write) begin
        ok = 1'b1;
        cyc = i;
        break;
      end
    end
  endtask

  // Called at a strobe negedge; returns at the negedge showing the finished pulse.
  task automatic wait_finish(output bit ok, output int strobe_cyc);
    ok = 1'b0;
    strobe_cyc = 1;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (req_finished != '0) begin
        ok = 1'b1;
        break;
      end
      if (sdram_read || sdram_write) strobe_cyc++;
    end
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    i_rst = 1'b0;
    @(negedge clk);
    total++;
    if ({sdram_read, sdram_write} !== 2'b00) begin
      bad++; $display("FAIL reset_strobes: got %b want 00", {sdram_read, sdram_write});
    end
    total++;
    if (req_finished !== 5'b0) begin
      bad++; $display("FAIL reset_finished: got %b want 00000", req_finished);
    end
    total++;
    if ({o_timeout, o_conflict} !== 2'b00) begin
      bad++; $display("FAIL reset_flags: got %b want 00", {o_timeout, o_conflict});
    end
    total++;
    if (req_readdata !== 32'h0 || sdram_addr !== 23'h0) begin
      bad++; $display("FAIL reset_data: got rd=%h addr=%h want 0/0", req_readdata, sdram_addr);
    end
    $display("test_reset: outputs idle after reset");
  endtask

  task automatic test_single_read();
    bit ok; int cyc; int sc;
    model_lat = 4;
    model_data = 32'hCAFEBABE;
    @(negedge clk);
    set_client(CLI_MIX, 1'b1, 1'b0, 23'h000123, 32'h0);
    wait_grant(ok, cyc);
    total++;
    if (!ok || cyc != 1 || sdram_read !== 1'b1 || sdram_addr !== 23'h000123) begin
      bad++; $display("FAIL single_grant: got ok=%0d cyc=%0d rd=%b addr=%h want 1/1/1/000123",
                      ok, cyc, sdram_read, sdram_addr);
    end
    wait_finish(ok, sc);
    req_read[CLI_MIX] = 1'b0;
    total++;
    if (!ok || sc != 4) begin
      bad++; $display("FAIL single_strobe_len: got ok=%0d cycles=%0d want 4", ok, sc);
    end
    total++;
    if (req_finished !== 5'b00100 || req_readdata !== 32'hCAFEBABE) begin
      bad++; $display("FAIL single_finish: got fin=%b data=%h want 00100/cafebabe",
                      req_finished, req_readdata);
    end
    @(negedge clk);
    total++;
    if (req_finished !== 5'b0) begin
      bad++; $display("FAIL single_pulse_width: got %b want 00000", req_finished);
    end
    $display("test_single_read: mix read addr=000123 data=%h", req_readdata);
    model_lat = 3;
  endtask

  task automatic test_priority();
    bit ok; int cyc; int sc;
    @(negedge clk);
    set_client(CLI_RECORD, 1'b0, 1'b1, 23'h000A00, 32'h11112222);
    set_client(CLI_PLAY,   1'b1, 1'b0, 23'h000B00, 32'h0);
    wait_grant(ok, cyc);
    total++;
    if (!ok || cyc != 1 || sdram_write !== 1'b1 || sdram_addr !== 23'h000A00 ||
        sdram_writedata !== 32'h11112222) begin
      bad++; $display("FAIL prio_first: got ok=%0d cyc=%0d wr=%b addr=%h wd=%h want record write",
                      ok, cyc, sdram_write, sdram_addr, sdram_writedata);
    end
    wait_finish(ok, sc);
    req_write[CLI_RECORD] = 1'b0;
    total++;
    if (!ok || req_finished !== 5'b00001) begin
      bad++; $display("FAIL prio_first_fin: got ok=%0d fin=%b want 00001", ok, req_finished);
    end
    wait_grant(ok, cyc);
    total++;
    if (!ok || cyc != 2 || sdram_read !== 1'b1 || sdram_addr !== 23'h000B00) begin
      bad++; $display("FAIL prio_second: got ok=%0d cyc=%0d rd=%b addr=%h want 1/2/1/000b00",
                      ok, cyc, sdram_read, sdram_addr);
    end
    wait_finish(ok, sc);
    req_read[CLI_PLAY] = 1'b0;
    total++;
    if (!ok || req_finished !== 5'b00010 || req_readdata !== 32'hCAFEBABE) begin
      bad++; $display("FAIL prio_second_fin: got ok=%0d fin=%b data=%h want 00010/cafebabe",
                      ok, req_finished, req_readdata);
    end
    $display("test_priority: record then play");
  endtask

  task automatic test_round_robin();
    bit ok; int cyc; int sc;
    int exp_order [6] = '{2, 3, 4, 2, 3, 4};
    do_reset();
    for (int c = 2; c < N; c++) set_client(c, 1'b1, 1'b0, AW'(32'h200 + c), 32'h0);
    for (int g = 0; g < 6; g++) begin
      wait_grant(ok, cyc);
      total++;
      if (!ok || sdram_addr !== AW'(32'h200 + exp_order[g])) begin
        bad++; $display("FAIL rr_grant%0d: got ok=%0d addr=%h want %h",
                        g, ok, sdram_addr, AW'(32'h200 + exp_order[g]));
      end
      wait_finish(ok, sc);
      total++;
      if (!ok || req_finished !== (N'(1) << exp_order[g])) begin
        bad++; $display("FAIL rr_fin%0d: got ok=%0d fin=%b want client %0d", g, ok, req_finished,
                        exp_order[g]);
      end
      $display("test_round_robin: grant %0d to client %0d", g, sdram_addr - AW'(32'h200));
    end
    req_read = '0;
  endtask

  task automatic test_holdoff();
    bit ok; int cyc; int sc; int busy;
    // Real-time client keeps its request through the IDLE cycle after finished.
    do_reset();
    set_client(CLI_RECORD, 1'b0, 1'b1, 23'h000A10, 32'h5);
    set_client(CLI_MIX,    1'b1, 1'b0, 23'h000A20, 32'h0);
    wait_grant(ok, cyc);
    wait_finish(ok, sc);
    total++;
    if (!ok || req_finished !== 5'b00001) begin
      bad++; $display("FAIL hold_rt_fin: got ok=%0d fin=%b want 00001", ok, req_finished);
    end
    @(negedge clk);
    req_write[CLI_RECORD] = 1'b0;
    wait_grant(ok, cyc);
    total++;
    if (!ok || cyc != 1 || sdram_addr !== 23'h000A20) begin
      bad++; $display("FAIL hold_rt_next: got ok=%0d cyc=%0d addr=%h want 1/1/000a20", ok, cyc, sdram_addr);
    end
    wait_finish(ok, sc);
    req_read[CLI_MIX] = 1'b0;
    $display("test_holdoff: record held through IDLE, mix served next");
    // Background variant: loaddata drops one cycle after its finished pulse.
    do_reset();
    set_client(CLI_LOAD, 1'b1, 1'b0, 23'h000A40, 32'h0);
    wait_grant(ok, cyc);
    set_client(CLI_MIX, 1'b1, 1'b0, 23'h000A20, 32'h0);
    wait_finish(ok, sc);
    total++;
    if (!ok || req_finished !== 5'b10000) begin
      bad++; $display("FAIL hold_load_fin: got ok=%0d fin=%b want 10000", ok, req_finished);
    end
    @(negedge clk);
    req_read[CLI_LOAD] = 1'b0;
    wait_grant(ok, cyc);
    total++;
    if (!ok || sdram_addr !== 23'h000A20) begin
      bad++; $display("FAIL hold_load_next: got ok=%0d addr=%h want 000a20", ok, sdram_addr);
    end
    wait_finish(ok, sc);
    req_read[CLI_MIX] = 1'b0;
    busy = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (sdram_read || sdram_write) busy++;
    end
    total++;
    if (busy != 0) begin
      bad++; $display("FAIL hold_no_reserve: got %0d strobe cycles want 0", busy);
    end
    $display("test_holdoff: loaddata not re-served, mix granted");
  endtask

  task automatic test_watchdog();
    bit ok; int cyc; int sc;
    model_en = 1'b0;
    @(negedge clk);
    set_client(CLI_PITCH, 1'b1, 1'b0, 23'h000C00, 32'h0);
    wait_grant(ok, cyc);
    wait_finish(ok, sc);
    req_read[CLI_PITCH] = 1'b0;
    total++;
    if (!ok || sc != 16) begin
      bad++; $display("FAIL wd_strobe_len: got ok=%0d cycles=%0d want 16", ok, sc);
    end
    total++;
    if (req_finished !== 5'b01000 || req_readdata !== 32'h0 || o_timeout !== 1'b1) begin
      bad++; $display("FAIL wd_abort: got fin=%b data=%h to=%b want 01000/0/1",
                      req_finished, req_readdata, o_timeout);
    end
    repeat (3) @(negedge clk);
    total++;
    if (o_timeout !== 1'b1 || sdram_read !== 1'b0) begin
      bad++; $display("FAIL wd_sticky: got to=%b rd=%b want 1/0", o_timeout, sdram_read);
    end
    $display("test_watchdog: abort after 15 wait cycles, timeout=%b", o_timeout);
  endtask

  task automatic test_reset_mid_wait();
    bit ok; int cyc; int seen;
    @(negedge clk);
    set_client(CLI_LOAD, 1'b0, 1'b1, 23'h000D00, 32'hDEAD0001);
    wait_grant(ok, cyc);
    repeat (3) @(negedge clk);
    i_rst = 1'b1;
    #1;
    total++;
    if ({sdram_read, sdram_write} !== 2'b00 || req_finished !== 5'b0 || o_timeout !== 1'b0) begin
      bad++; $display("FAIL rst_mid_wait: got strobes=%b fin=%b to=%b want 00/00000/0",
                      {sdram_read, sdram_write}, req_finished, o_timeout);
    end
    req_write = '0;
    @(negedge clk);
    i_rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (req_finished != '0 || sdram_read || sdram_write) seen++;
    end
    total++;
    if (seen != 0) begin
      bad++; $display("FAIL rst_no_pulse: got %0d active cycles want 0", seen);
    end
    $display("test_reset_mid_wait: transaction dropped by reset");
    model_en = 1'b1;
  endtask

  task automatic test_conflict();
    bit ok; int cyc; int sc;
    total++;
    if (o_conflict !== 1'b0) begin
      bad++; $display("FAIL conflict_pre: got %b want 0", o_conflict);
    end
    @(negedge clk);
    set_client(CLI_MIX, 1'b1, 1'b1, 23'h000E00, 32'h0BADF00D);
    wait_grant(ok, cyc);
    total++;
    if (!ok || {sdram_read, sdram_write} !== 2'b01 || sdram_writedata !== 32'h0BADF00D) begin
      bad++; $display("FAIL conflict_op: got ok=%0d rd/wr=%b wd=%h want 01/0badf00d",
                      ok, {sdram_read, sdram_write}, sdram_writedata);
    end
    wait_finish(ok, sc);
    req_read[CLI_MIX]  = 1'b0;
    req_write[CLI_MIX] = 1'b0;
    total++;
    if (!ok || o_conflict !== 1'b1 || req_finished !== 5'b00100) begin
      bad++; $display("FAIL conflict_flag: got ok=%0d flag=%b fin=%b want 1/00100", ok, o_conflict,
                      req_finished);
    end
    $display("test_conflict: read+write issued as write, conflict=%b", o_conflict);
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_priority();
    test_round_robin();
    test_holdoff();
    test_watchdog();
    test_reset_mid_wait();
    test_conflict();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
